// File: rtl/tt_um_waves_pkg.sv
// Shared constants for the waveform generator: select codes, phase/FTW geometry, LFSR setup.
// No logic or latency here; the noise constants are only used when WAVES_NOISE_EN is defined.
package tt_um_waves_pkg;

    typedef enum logic [2:0] {
        WAVE_SQUARE = 3'b000,
        WAVE_SAW    = 3'b001,
        WAVE_TRI    = 3'b010,
        WAVE_SINE   = 3'b011,
        WAVE_NOISE  = 3'b100
    } wave_sel_e;

    localparam int          PHASE_W   = 16;
    localparam int          FTW_W     = 8;
    localparam int          FTW_SHIFT = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [7:0]  MIDSCALE  = 8'h80;

    function automatic logic [7:0] tri_from_phase(input logic [7:0] p);
        return p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/waves_sine_lut.sv
// Quarter-wave sine magnitude ROM, 64 x 7 bits, LUT[i] = round(127*sin(2*pi*(i+0.5)/256)).
// Purely combinational, zero latency, no flow control.
module waves_sine_lut (
    input  logic [5:0] idx_i,
    output logic [6:0] mag_o
);

    localparam logic [6:0] LUT [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    assign mag_o = LUT[idx_i];

endmodule

// File: rtl/tt_um_waves.sv
// DDS waveform generator (square/saw/triangle/sine, plus LFSR noise when WAVES_NOISE_EN is defined).
// One clock from phase to uo_out; no backpressure, ena=0 freezes every register.
module tt_um_waves
    import tt_um_waves_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] ftw_ext;
    logic [7:0]         p;
    logic [7:0]         sample_q, sample_d;
    logic [7:0]         raw;
    logic [7:0]         shifted;
    logic [5:0]         sine_idx;
    logic [6:0]         sine_mag;
    logic [7:0]         sine_s;
    logic               clear, run;
    wave_sel_e          sel;

    assign clear   = ui_in[4];
    assign run     = ui_in[3];
    assign sel     = wave_sel_e'(ui_in[2:0]);
    assign ftw_ext = {{(PHASE_W-FTW_W-FTW_SHIFT){1'b0}}, uio_in, {FTW_SHIFT{1'b0}}};
    assign p       = phase_q[PHASE_W-1 -: 8];

    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (run) begin
            phase_d = phase_q + ftw_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (ena) begin
            phase_q <= phase_d;
        end
    end

`ifdef WAVES_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

    // Noise steps in lockstep with the phase accumulator, so it holds on clear or run=0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (run && !clear) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (ena) begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign sine_idx = p[6] ? ~p[5:0] : p[5:0];

    waves_sine_lut u_sine_lut (
        .idx_i (sine_idx),
        .mag_o (sine_mag)
    );

    assign sine_s = p[7] ? (8'd127 - {1'b0, sine_mag}) : (8'd128 + {1'b0, sine_mag});

    always_comb begin
        raw = MIDSCALE;
        case (sel)
            WAVE_SQUARE: raw = p[7] ? 8'h00 : 8'hFF;
            WAVE_SAW:    raw = p;
            WAVE_TRI:    raw = tri_from_phase(p);
            WAVE_SINE:   raw = sine_s;
`ifdef WAVES_NOISE_EN
            WAVE_NOISE:  raw = lfsr_q[7:0];
`endif
            default:     raw = MIDSCALE;
        endcase
    end

    assign shifted  = raw >> ui_in[6:5];
    assign sample_d = ui_in[7] ? ~shifted : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 8'h00;
        end else if (ena) begin
            sample_q <= sample_d;
        end
    end

    assign uo_out  = sample_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_waves.sv
// Directed bench for tt_um_waves: reset, each waveform, attenuation/invert, hold, freeze, clear, noise.
// Expected samples are hand-computed from the phase sequence (FTW 0x10 steps p by one per clock).
module tb_tt_um_waves;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_waves dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        #2;
        check(tag, uo_out, 8'h00);
        #1;
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset state and first square sample at p=0
        do_reset("reset_uo");
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
        tick();
        check("square_first", uo_out, 8'hFF);

        // Saw: one LSB per clock, wrapping 0xFF -> 0x00
        do_reset("reset_saw");
        ui_in  = 8'h09;
        uio_in = 8'h10;
        for (int k = 1; k <= 257; k++) begin
            tick();
            check("saw_step", uo_out, 8'(k - 1));
        end

        // Sine: selected points of the table
        do_reset("reset_sine");
        ui_in  = 8'h0B;
        uio_in = 8'h10;
        for (int k = 1; k <= 193; k++) begin
            tick();
            if (k == 1)   check("sine_p0", uo_out, 8'h82);
            if (k == 2)   check("sine_p1", uo_out, 8'h85);
            if (k == 33)  check("sine_p32", uo_out, 8'hDB);
            if (k == 64)  check("sine_p63", uo_out, 8'hFF);
            if (k == 65)  check("sine_p64", uo_out, 8'hFF);
            if (k == 129) check("sine_p128", uo_out, 8'h7D);
            if (k == 192) check("sine_p191", uo_out, 8'h00);
            if (k == 193) check("sine_p192", uo_out, 8'h00);
        end

        // Triangle, attenuation 2, inverted
        do_reset("reset_tri");
        ui_in  = 8'hCA;
        uio_in = 8'h10;
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (k == 1)  check("tri_p0", uo_out, 8'hFF);
            if (k == 33) check("tri_p32", uo_out, 8'hEF);
            if (k == 65) check("tri_p64", uo_out, 8'hDF);
        end

        // ena=0 holds output and phase (p stays 65)
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_uo", uo_out, 8'hDF);
        end
        ena = 1'b1;
        tick();
        check("hold_p65", uo_out, 8'hDF);
        tick();
        check("hold_p66", uo_out, 8'hDE);

        // Shape change without phase reset: saw shows p=67
        ui_in = 8'h09;
        tick();
        check("switch_saw", uo_out, 8'h43);

        // FTW=0 freezes p at 68
        uio_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ftw0_freeze", uo_out, 8'h44);
        end

        // Phase clear beats advance
        uio_in = 8'h10;
        ui_in  = 8'h19;
        tick();
        check("clear_edge", uo_out, 8'h44);
        ui_in = 8'h09;
        tick();
        check("clear_p0", uo_out, 8'h00);
        tick();
        check("clear_p1", uo_out, 8'h01);

        // Square attenuated by 3 at p=2; unused selects give midscale
        ui_in = 8'h68;
        tick();
        check("square_att3", uo_out, 8'h1F);
        ui_in = 8'h0D;
        tick();
        check("sel5_mid", uo_out, 8'h80);
        ui_in = 8'h8D;
        tick();
        check("sel5_inv", uo_out, 8'h7F);

        // Asynchronous reset without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", uo_out, 8'h00);
        #2;
        rst_n = 1'b1;

        // Noise from seed 0xACE1
        ui_in  = 8'h0C;
        uio_in = 8'h10;
`ifdef WAVES_NOISE_EN
        tick(); check("noise_0", uo_out, 8'hE1);
        tick(); check("noise_1", uo_out, 8'h70);
        tick(); check("noise_2", uo_out, 8'h38);
        tick(); check("noise_3", uo_out, 8'h9C);
`else
        tick(); check("noise_off_0", uo_out, 8'h80);
        tick(); check("noise_off_1", uo_out, 8'h80);
        tick(); check("noise_off_2", uo_out, 8'h80);
        tick(); check("noise_off_3", uo_out, 8'h80);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_waves.md
TT_UM_WAVES -- requirements
Module: tt_um_waves

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: ena  input  1  design enable; when 0, all registers hold their value.
REQ-004 SHALL: ui_in  input  8  control bits:
- [2:0] waveform select
- [3] run
- [4] synchronous phase clear
- [6:5] attenuation shift
- [7] output invert
REQ-005 SHALL: uio_in  input  8  frequency tuning word (FTW).
REQ-006 SHALL: uo_out  output  8  registered unsigned waveform sample.
REQ-007 SHALL: uio_out  output  8  constant 0x00.
REQ-008 SHALL: uio_oe  output  8  constant 0x00; all bidirectional pins are inputs.

Function
REQ-009 SHALL: 16-bit phase register P; the 8-bit phase is p = P[15:8].
REQ-010 SHALL: on each edge with ena=1 and ui_in[3]=1, P <= P + {4'h0, uio_in, 4'h0}, modulo 2^16 with silent wrap.
REQ-011 SHALL: on an edge with ena=1 and ui_in[4]=1, P <= 0; this has priority over advance.
REQ-012 SHALL: raw sample s is combinational from the current p, selected by ui_in[2:0]:
- 000 square: p[7] ? 0x00 : 0xFF
- 001 saw: p
- 010 triangle: p[7] ? ~{p[6:0],0} : {p[6:0],0}
- 011 sine: see REQ-013
- 100 noise: see REQ-014
- 101..111: 0x80
REQ-013 SHALL: sine uses a 64-entry 7-bit quarter-wave ROM with LUT[i] = round(127*sin(2*pi*(i+0.5)/256)).
- ROM index = p[6] ? ~p[5:0] : p[5:0]
- m = LUT[index]
- s = p[7] ? 127 - m : 128 + m
REQ-014 SHALL: noise is a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- Seed 0xACE1.
- Advances under the same condition as P advances.
- s = lfsr[7:0].
REQ-015 SHALL: with ena=1, uo_out <= (s >> ui_in[6:5]), bitwise inverted when ui_in[7]=1; latency is one clock from p to uo_out.
REQ-016 SHALL: changing ui_in[2:0] SHALL NOT reset P or the LFSR; the new shape appears on uo_out at the next edge.
REQ-017 SHALL: FTW=0 with run=1 freezes p, and uo_out stays constant.

Reset
REQ-018 SHALL: with rst_n=0, immediately P=0x0000, lfsr=0xACE1 and uo_out=0x00, independent of clk and ena.
REQ-019 SHALL: after rst_n is released, the first update occurs at the next rising edge with ena=1.

Configuration
REQ-020 SHALL: macro WAVES_NOISE_EN controls the noise waveform.
- Defined: the LFSR and waveform 100 are present.
- Undefined: no LFSR is synthesized, and select 100 yields 0x80 like 101..111.

Structure
REQ-021 SHALL: package tt_um_waves_pkg holds:
- waveform select codes
- phase width (16) and FTW shift (4)
- LFSR seed and taps
- midscale constant 0x80
REQ-022 SHALL: sub-module waves_sine_lut holds the 64x7 combinational quarter-wave ROM; all other logic sits in tt_um_waves.

Verification
REQ-023 SHALL: reset with rst_n=0 and ena=0, then release and set ena=1 with ui_in=0x00 -> uo_out=0x00 during reset; first sample 0xFF (square, p=0).
REQ-024 SHALL: saw, ui_in=0x09, uio_in=0x10 -> uo_out steps +1 per clock (0,0,1,2,...), wrapping 0xFF->0x00.
REQ-025 SHALL: sine, ui_in=0x0B, uio_in=0x10 -> first sample 0x82, peak 0xFF at p=63/64, trough 0x00 at p=191/192.
REQ-026 SHALL: triangle with attenuation 2 and invert (ui_in=0xCA), uio_in=0x10, at p=0x40 -> uo_out = ~(0x80>>2) = 0xDF.
REQ-027 SHALL: run=1, then ena=0 for 10 clocks -> uo_out and P unchanged.
REQ-028 SHALL: noise with WAVES_NOISE_EN, run, after reset -> first samples follow the LFSR from 0xACE1; without the macro -> 0x80 constant.
